// File: rtl/fpu_issue_controller.sv
// fpu_issue_controller
// Issue/handshake stage in front of the fixed-point unit. Requests are
// registered onto the unit's inputs, the unit's ready is sampled only once
// the operands have had a full cycle to settle, and the result is returned
// with its tag over a valid/ready response port. A bounded wait turns a hung
// unit into an error response, abort cancels an in-flight operation, and
// handed-off responses are counted.

module fpu_issue_controller #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_operand_1,
    input  logic [WIDTH-1:0] req_operand_2,
    input  logic [1:0]       req_operation,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    input  logic             abort,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_error,
    output logic             busy,
    output logic [15:0]      done_count,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Last WAIT count value before the wait is abandoned as a timeout.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opnd1_q, opnd1_d;
    logic [WIDTH-1:0] opnd2_q, opnd2_d;
    logic [1:0]       operation_q, operation_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [15:0]      waitCnt_q, waitCnt_d;
    logic [WIDTH-1:0] rspResult_q, rspResult_d;
    logic             rspError_q, rspError_d;
    logic [15:0]      doneCnt_q, doneCnt_d;
    logic [7:0]       errCnt_q, errCnt_d;
    logic             unitReady;

    // The unit's ready is combinational and may float; only a solid 1 counts.
    assign unitReady = (fpu_ready === 1'b1);

    assign req_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RESP);
    assign busy          = (state_q != IDLE);
    assign fpu_operand_1 = opnd1_q;
    assign fpu_operand_2 = opnd2_q;
    assign fpu_operation = operation_q;
    assign rsp_result    = rspResult_q;
    assign rsp_tag       = tag_q;
    assign rsp_error     = rspError_q;
    assign done_count    = doneCnt_q;
    assign err_count     = errCnt_q;

    // Next-state and datapath updates; ISSUE deliberately ignores fpu_ready
    // because it still reflects the previous operation.
    always_comb begin
        state_d     = state_q;
        opnd1_d     = opnd1_q;
        opnd2_d     = opnd2_q;
        operation_d = operation_q;
        tag_d       = tag_q;
        waitCnt_d   = waitCnt_q;
        rspResult_d = rspResult_q;
        rspError_d  = rspError_q;
        doneCnt_d   = doneCnt_q;
        errCnt_d    = errCnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    opnd1_d     = req_operand_1;
                    opnd2_d     = req_operand_2;
                    operation_d = req_operation;
                    tag_d       = req_tag;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    waitCnt_d = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (unitReady) begin
                    rspResult_d = fpu_result;
                    rspError_d  = 1'b0;
                    state_d     = RESP;
                end else if (waitCnt_q == WAIT_LAST) begin
                    rspResult_d = '0;
                    rspError_d  = 1'b1;
                    state_d     = RESP;
                end else begin
                    waitCnt_d = waitCnt_q + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    doneCnt_d = doneCnt_q + 16'd1;
                    if (rspError_q && (errCnt_q != 8'hFF)) begin
                        errCnt_d = errCnt_q + 8'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, response and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opnd1_q     <= '0;
            opnd2_q     <= '0;
            operation_q <= 2'b00;
            tag_q       <= '0;
            waitCnt_q   <= '0;
            rspResult_q <= '0;
            rspError_q  <= 1'b0;
            doneCnt_q   <= '0;
            errCnt_q    <= '0;
        end else begin
            opnd1_q     <= opnd1_d;
            opnd2_q     <= opnd2_d;
            operation_q <= operation_d;
            tag_q       <= tag_d;
            waitCnt_q   <= waitCnt_d;
            rspResult_q <= rspResult_d;
            rspError_q  <= rspError_d;
            doneCnt_q   <= doneCnt_d;
            errCnt_q    <= errCnt_d;
        end
    end

endmodule

// File: tb/tb_fpu_issue_controller.sv
// tb_fpu_issue_controller
// Drives directed and random requests into fpu_issue_controller with a
// stand-in fixed-point unit whose ready timing the bench controls per
// transaction. Expected response timing, contents and counters come from a
// transaction-level model of the controller's rules.

module tb_fpu_issue_controller;

    localparam int WIDTH   = 32;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 8;

    localparam logic [1:0] FPU_ADD  = 2'd0;
    localparam logic [1:0] FPU_SUB  = 2'd1;
    localparam logic [1:0] FPU_MUL  = 2'd2;
    localparam logic [1:0] FPU_SQRT = 2'd3;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_operand_1;
    logic [WIDTH-1:0] req_operand_2;
    logic [1:0]       req_operation;
    logic [TAG_W-1:0] req_tag;
    logic [WIDTH-1:0] fpu_operand_1;
    logic [WIDTH-1:0] fpu_operand_2;
    logic [1:0]       fpu_operation;
    logic [WIDTH-1:0] fpu_result;
    logic             fpu_ready;
    logic             abort;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_error;
    logic             busy;
    logic [15:0]      done_count;
    logic [7:0]       err_count;

    int          vectors;
    int          miscompares;
    logic [15:0] expDone;
    logic [7:0]  expErr;

    fpu_issue_controller #(
        .WIDTH  (WIDTH),
        .TAG_W  (TAG_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_operand_1(req_operand_1),
        .req_operand_2(req_operand_2),
        .req_operation(req_operation),
        .req_tag      (req_tag),
        .fpu_operand_1(fpu_operand_1),
        .fpu_operand_2(fpu_operand_2),
        .fpu_operation(fpu_operation),
        .fpu_result   (fpu_result),
        .fpu_ready    (fpu_ready),
        .abort        (abort),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_tag      (rsp_tag),
        .rsp_error    (rsp_error),
        .busy         (busy),
        .done_count   (done_count),
        .err_count    (err_count)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Stand-in arithmetic for the unit; only needs to be a distinct function
    // of operands and operation so mis-registered inputs show up in results.
    function automatic logic [31:0] unitModel(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        logic [31:0] r;
        case (op)
            FPU_ADD: r = a + b;
            FPU_SUB: r = a - b;
            FPU_MUL: r = a * b;
            default: r = (a >> 1) ^ 32'h5A5A_0000;
        endcase
        return r;
    endfunction

    assign fpu_result = unitModel(fpu_operand_1, fpu_operand_2, fpu_operation);

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
        end
    endtask

    // One request from acceptance to handoff (or abort). readyK is the WAIT
    // sample index where the unit reports ready (-1 never), abortK the WAIT
    // sample index carrying abort (-1 none), stall the RESP backpressure cycles.
    // Called and returning at a negative edge with the controller idle.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] tag,
                                 input int readyK, input int abortK, input int stall);
        int          respEdge;
        int          abortEdge;
        int          lastEdge;
        bit          responds;
        bit          isErr;
        logic [31:0] expRes;

        if (readyK >= 0 && readyK <= TIMEOUT - 1) begin
            respEdge = 2 + readyK;
            isErr    = 1'b0;
            expRes   = unitModel(a, b, op);
        end else begin
            respEdge = 1 + TIMEOUT;
            isErr    = 1'b1;
            expRes   = 32'h0;
        end
        abortEdge = (abortK >= 0) ? 2 + abortK : -1;
        responds  = !(abortK >= 0 && abortEdge <= respEdge);
        lastEdge  = responds ? respEdge : abortEdge;

        checkOutput("idle_req_ready", 32'(req_ready), 32'd1);
        rsp_ready     = 1'b0;
        abort         = 1'b0;
        req_valid     = 1'b1;
        req_operand_1 = a;
        req_operand_2 = b;
        req_operation = op;
        req_tag       = tag;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("issue_busy", 32'(busy), 32'd1);
        checkOutput("issue_req_ready", 32'(req_ready), 32'd0);
        checkOutput("issue_operand_1", fpu_operand_1, a);
        checkOutput("issue_operand_2", fpu_operand_2, b);
        checkOutput("issue_operation", 32'(fpu_operation), 32'(op));

        for (int e = 1; e <= lastEdge; e++) begin
            // Ready is held high across the ISSUE edge to mimic a stale unit.
            fpu_ready = (e == 1) ? 1'b1 : (readyK >= 0 && (e - 2) >= readyK);
            abort     = (abortK >= 0 && (e - 2) == abortK);
            @(negedge clk);
            if (e < lastEdge) begin
                checkOutput("wait_rsp_valid", 32'(rsp_valid), 32'd0);
                checkOutput("wait_busy", 32'(busy), 32'd1);
            end
        end
        abort = 1'b0;

        if (!responds) begin
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
            checkOutput("abort_done_count", 32'(done_count), 32'(expDone));
            checkOutput("abort_err_count", 32'(err_count), 32'(expErr));
        end else begin
            checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("rsp_result", rsp_result, expRes);
            checkOutput("rsp_tag", 32'(rsp_tag), 32'(tag));
            checkOutput("rsp_error", 32'(rsp_error), 32'(isErr));
            checkOutput("rsp_req_ready", 32'(req_ready), 32'd0);
            for (int s = 0; s < stall; s++) begin
                req_valid     = 1'b1;
                req_operand_1 = ~a;
                req_tag       = ~tag;
                abort         = (s == 0);
                @(negedge clk);
                checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'd1);
                checkOutput("stall_rsp_result", rsp_result, expRes);
                checkOutput("stall_rsp_tag", 32'(rsp_tag), 32'(tag));
                checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
                checkOutput("stall_operand_1", fpu_operand_1, a);
            end
            abort     = 1'b0;
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            expDone = expDone + 16'd1;
            if (isErr && expErr != 8'hFF) expErr = expErr + 8'd1;
            checkOutput("handoff_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("handoff_busy", 32'(busy), 32'd0);
            checkOutput("handoff_operand_1", fpu_operand_1, a);
            checkOutput("handoff_done_count", 32'(done_count), 32'(expDone));
            checkOutput("handoff_err_count", 32'(err_count), 32'(expErr));
        end
    endtask

    // Directed scenarios, then random traffic, then error-counter saturation.
    initial begin
        int          readyK;
        int          abortK;
        logic [1:0]  op;

        clk           = 1'b0;
        reset         = 1'b0;
        req_valid     = 1'b0;
        req_operand_1 = '0;
        req_operand_2 = '0;
        req_operation = '0;
        req_tag       = '0;
        fpu_ready     = 1'b0;
        abort         = 1'b0;
        rsp_ready     = 1'b0;
        vectors       = 0;
        miscompares   = 0;
        expDone       = '0;
        expErr        = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_operand_1", fpu_operand_1, 32'h0);
        checkOutput("reset_operation", 32'(fpu_operation), 32'd0);
        checkOutput("reset_rsp_result", rsp_result, 32'h0);
        checkOutput("reset_rsp_tag", 32'(rsp_tag), 32'd0);
        checkOutput("reset_done_count", 32'(done_count), 32'd0);
        checkOutput("reset_err_count", 32'(err_count), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] single-cycle ADD");
        applyStimulus(FPU_ADD, 32'h0000_0C00, 32'h0000_0400, 4'd3, 0, -1, 0);
        checkOutput("add_result_value", unitModel(32'h0000_0C00, 32'h0000_0400, FPU_ADD),
                    32'h0000_1000);

        $display("[TB] stale ready, 5-cycle MUL");
        applyStimulus(FPU_MUL, 32'h0001_2345, 32'h0000_0101, 4'd7, 4, -1, 0);

        $display("[TB] abort coincident with ready");
        applyStimulus(FPU_SUB, 32'h0000_9000, 32'h0000_0001, 4'd5, 1, 1, 0);

        $display("[TB] backpressure with abort in RESP");
        applyStimulus(FPU_SQRT, 32'h0004_0000, 32'h0, 4'd9, 0, -1, 10);

        $display("[TB] reset during WAIT");
        req_valid     = 1'b1;
        req_operation = FPU_MUL;
        req_operand_1 = 32'h0000_0033;
        req_operand_2 = 32'h0000_0044;
        req_tag       = 4'd12;
        @(negedge clk);
        req_valid = 1'b0;
        fpu_ready = 1'b0;
        repeat (2) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midreset_operation", 32'(fpu_operation), 32'd0);
        checkOutput("midreset_done_count", 32'(done_count), 32'd0);
        checkOutput("midreset_err_count", 32'(err_count), 32'd0);
        expDone = '0;
        expErr  = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] timeout");
        applyStimulus(FPU_MUL, 32'h0000_0002, 32'h0000_0003, 4'd4, -1, -1, 0);
        checkOutput("timeout_err_is_one", 32'(err_count), 32'd1);
        checkOutput("timeout_done_is_one", 32'(done_count), 32'd1);

        $display("[TB] ready on the last WAIT sample");
        applyStimulus(FPU_ADD, 32'h1111_1111, 32'h2222_2222, 4'd1, TIMEOUT - 1, -1, 1);

        $display("[TB] random traffic");
        for (int n = 0; n < 40; n++) begin
            op     = 2'($urandom_range(0, 3));
            readyK = int'($urandom_range(0, TIMEOUT + 1));
            abortK = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            applyStimulus(op, $urandom, $urandom, 4'($urandom_range(0, 15)), readyK, abortK,
                          int'($urandom_range(0, 3)));
        end

        $display("[TB] error counter saturation");
        for (int n = 0; n < 260; n++) begin
            applyStimulus(FPU_SUB, 32'(n), 32'h1, 4'(n), -1, -1, 0);
        end
        checkOutput("err_count_saturated", 32'(err_count), 32'h0000_00FF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
